// File: rtl/risc_v_mike_pkg.sv
// Shared types and default memory map for the core's load/store region controller.
// Latency: n/a (types and constants only); backpressure: n/a.
package risc_v_mike_pkg;

  localparam logic [31:0] TEXT_LOWER  = 32'h0040_0000;
  localparam logic [31:0] DATA_LOWER  = 32'h1001_0000;
  localparam logic [31:0] STACK_UPPER = 32'h7FFF_EFFF;
  localparam logic [31:0] MMIO_LOWER  = 32'hFFFF_0000;

  localparam int DEF_N_REGIONS = 4;

  // The stack region is the 2 KiB window ending at STACK_UPPER.
  localparam logic [31:0] DEF_REGION_BASE [DEF_N_REGIONS] =
    '{TEXT_LOWER, DATA_LOWER, STACK_UPPER - 32'h0000_07FF, MMIO_LOWER};
  localparam logic [31:0] DEF_REGION_SIZE [DEF_N_REGIONS] =
    '{32'h0000_1000, 32'h0000_0800, 32'h0000_0800, 32'h0000_0100};

  typedef logic [$clog2(DEF_N_REGIONS)-1:0] region_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } mem_ctrl_state_e;

endpackage

// File: rtl/risc_v_addr_decode.sv
// Combinational address-to-region decoder: priority one-hot hit and region-relative offset.
// Latency: 0 cycles; backpressure: none (pure function of addr).
module risc_v_addr_decode
  import risc_v_mike_pkg::*;
#(
  parameter int                N_REGIONS = DEF_N_REGIONS,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] REGION_BASE [N_REGIONS] = DEF_REGION_BASE,
  parameter logic [DATA_W-1:0] REGION_SIZE [N_REGIONS] = DEF_REGION_SIZE
) (
  input  logic [DATA_W-1:0]    addr,
  output logic [N_REGIONS-1:0] hit_vec,
  output logic                 hit,
  output logic [DATA_W-1:0]    offset
);

  // One extra bit on the bounds keeps a region ending at the top of memory from wrapping.
  always_comb begin
    hit_vec = '0;
    hit     = 1'b0;
    offset  = '0;
    for (int i = 0; i < N_REGIONS; i++) begin
      if (!hit &&
          ({1'b0, addr} >= {1'b0, REGION_BASE[i]}) &&
          ({1'b0, addr} <  ({1'b0, REGION_BASE[i]} + {1'b0, REGION_SIZE[i]}))) begin
        hit_vec[i] = 1'b1;
        hit        = 1'b1;
        offset     = addr - REGION_BASE[i];
      end
    end
  end

endmodule

// File: rtl/risc_v_mem_region_ctrl.sv
// Sequential load/store router: decodes a core request to one region, waits for ack or timeout.
// Latency: unmapped 1 cycle, hit ack-time+1, timeout TIMEOUT_CYCLES+1; req_ready low until RESP done.
module risc_v_mem_region_ctrl
  import risc_v_mike_pkg::*;
#(
  parameter int                N_REGIONS      = DEF_N_REGIONS,
  parameter int                DATA_W         = 32,
  parameter logic [DATA_W-1:0] REGION_BASE [N_REGIONS] = DEF_REGION_BASE,
  parameter logic [DATA_W-1:0] REGION_SIZE [N_REGIONS] = DEF_REGION_SIZE,
  parameter int                TIMEOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [DATA_W-1:0]             req_addr,
  input  logic [DATA_W-1:0]             req_wdata,
  input  logic [DATA_W/8-1:0]           req_be,
  output logic                          rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          rsp_err,
  output logic [N_REGIONS-1:0]          reg_sel,
  output logic                          reg_we,
  output logic [DATA_W-1:0]             reg_offset,
  output logic [DATA_W-1:0]             reg_wdata,
  output logic [DATA_W/8-1:0]           reg_be,
  input  logic [N_REGIONS*DATA_W-1:0]   reg_rdata,
  input  logic [N_REGIONS-1:0]          reg_ack
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mem_ctrl_state_e state_q, state_d;

  logic [N_REGIONS-1:0] sel_q;
  logic                 we_q;
  logic [DATA_W-1:0]    offset_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [DATA_W/8-1:0]  be_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [DATA_W-1:0]    rdata_q;
  logic                 err_q;

  logic [N_REGIONS-1:0] dec_hit_vec;
  logic                 dec_hit;
  logic [DATA_W-1:0]    dec_offset;

  logic                 accept;
  logic                 ack_sel;
  logic                 acc_done;
  logic                 acc_timeout;
  logic [DATA_W-1:0]    rdata_mux;

  risc_v_addr_decode #(
    .N_REGIONS   (N_REGIONS),
    .DATA_W      (DATA_W),
    .REGION_BASE (REGION_BASE),
    .REGION_SIZE (REGION_SIZE)
  ) u_decode (
    .addr    (req_addr),
    .hit_vec (dec_hit_vec),
    .hit     (dec_hit),
    .offset  (dec_offset)
  );

  // Only the selected region's ack counts; acks outside ACCESS are dropped by the FSM.
  assign ack_sel = |(reg_ack & sel_q);

  always_comb begin
    rdata_mux = '0;
    for (int i = 0; i < N_REGIONS; i++) begin
      if (sel_q[i]) rdata_mux = rdata_mux | reg_rdata[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    acc_done    = 1'b0;
    acc_timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = dec_hit ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        // An ack on the last counted cycle takes precedence over the timeout.
        if (ack_sel) begin
          acc_done = 1'b1;
          state_d  = RESP;
        end else if (cnt_q == CNT_ONE) begin
          acc_timeout = 1'b1;
          state_d     = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q    <= '0;
      we_q     <= 1'b0;
      offset_q <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      sel_q    <= dec_hit_vec;
      we_q     <= req_we;
      offset_q <= dec_offset;
      wdata_q  <= req_wdata;
      be_q     <= req_be;
      cnt_q    <= CNT_LOAD;
      rdata_q  <= '0;
      err_q    <= ~dec_hit;
    end else if (acc_done) begin
      rdata_q <= we_q ? '0 : rdata_mux;
      err_q   <= 1'b0;
    end else if (acc_timeout) begin
      rdata_q <= '0;
      err_q   <= 1'b1;
    end else if (state_q == ACCESS) begin
      cnt_q <= cnt_q - CNT_ONE;
    end
  end

  // Select and strobe are state-qualified so reset drops them without waiting for a clock.
  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_err    = rsp_valid & err_q;
  assign rsp_rdata  = rsp_valid ? rdata_q : '0;
  assign reg_sel    = (state_q == ACCESS) ? sel_q : '0;
  assign reg_we     = (state_q == ACCESS) & we_q;
  assign reg_offset = offset_q;
  assign reg_wdata  = wdata_q;
  assign reg_be     = be_q;

endmodule

// File: tb/tb_risc_v_mem_region_ctrl.sv
// Self-checking bench for risc_v_mem_region_ctrl: directed table, corner sequences, random vs model.
module tb_risc_v_mem_region_ctrl;

  localparam int T = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [31:0]  req_addr;
  logic [31:0]  req_wdata;
  logic [3:0]   req_be;
  logic         rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic [3:0]   reg_sel;
  logic         reg_we;
  logic [31:0]  reg_offset;
  logic [31:0]  reg_wdata;
  logic [3:0]   reg_be;
  logic [127:0] reg_rdata;
  logic [3:0]   reg_ack;

  risc_v_mem_region_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .reg_sel    (reg_sel),
    .reg_we     (reg_we),
    .reg_offset (reg_offset),
    .reg_wdata  (reg_wdata),
    .reg_be     (reg_be),
    .reg_rdata  (reg_rdata),
    .reg_ack    (reg_ack)
  );

  always #5 clk = ~clk;

  // Memory map as documented for the core: text, data, stack, MMIO.
  logic [31:0] rb [4] = '{32'h0040_0000, 32'h1001_0000, 32'h7FFF_E800, 32'hFFFF_0000};
  logic [31:0] rs [4] = '{32'h0000_1000, 32'h0000_0800, 32'h0000_0800, 32'h0000_0100};

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          ack_k;      // cycle after acceptance whose closing edge sees the ack; 0 = never
    logic [31:0] ack_rdata;
    int          stray;      // region that acks spuriously in cycle 2; -1 = none
    logic [3:0]  exp_sel;
    logic [31:0] exp_off;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_cyc;    // cycle (1 = first after acceptance) holding rsp_valid
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int model_region(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if (a >= rb[i] && (a - rb[i]) < rs[i]) return i;
    return -1;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    int          tgt;
    int          got_cyc;
    logic        got_err;
    logic [31:0] got_rd;
    tgt = -1;
    for (int i = 0; i < 4; i++) if (v.exp_sel[i]) tgt = i;
    got_cyc = 0;
    got_err = 1'b0;
    got_rd  = '0;
    chk({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_be    = v.be;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
    req_we    = 1'($urandom);
    for (int c = 1; c <= T + 4; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 1) begin
        chk({tag, ".sel"}, {28'b0, reg_sel}, {28'b0, v.exp_sel});
        if (v.exp_sel != 4'b0) begin
          chk({tag, ".offset"}, reg_offset, v.exp_off);
          chk({tag, ".we"}, {31'b0, reg_we}, {31'b0, v.we});
          chk({tag, ".be"}, {28'b0, reg_be}, {28'b0, v.be});
          chk({tag, ".wdata"}, reg_wdata, v.wdata);
        end
      end
      if (rsp_valid) begin
        got_cyc = c;
        got_err = rsp_err;
        got_rd  = rsp_rdata;
        chk({tag, ".sel_in_resp"}, {28'b0, reg_sel}, 32'd0);
        break;
      end
      reg_rdata = {$urandom, $urandom, $urandom, $urandom};
      reg_ack   = 4'b0;
      if (tgt >= 0 && c == v.ack_k) begin
        reg_ack[tgt] = 1'b1;
        reg_rdata[tgt*32 +: 32] = v.ack_rdata;
      end
      if (v.stray >= 0 && c == 2) reg_ack[v.stray] = 1'b1;
    end
    reg_ack = 4'b0;
    chk({tag, ".rsp_cycle"}, 32'(got_cyc), 32'(v.exp_cyc));
    chk({tag, ".err"}, {31'b0, got_err}, {31'b0, v.exp_err});
    chk({tag, ".rdata"}, got_rd, v.exp_rdata);
    @(negedge clk);
    chk({tag, ".pulse_end"}, {31'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    vec_t v;
    int   r, mode, reg_i;
    bit   acked;

    vecs[0]  = '{we:0, addr:32'h1001_0010, wdata:0, be:4'hF, ack_k:3, ack_rdata:32'hDEAD_BEEF, stray:3,
                 exp_sel:4'b0010, exp_off:32'h10, exp_err:0, exp_rdata:32'hDEAD_BEEF, exp_cyc:4};
    vecs[1]  = '{we:1, addr:32'hFFFF_0004, wdata:32'h1234, be:4'b0011, ack_k:1, ack_rdata:32'hAAAA_5555, stray:-1,
                 exp_sel:4'b1000, exp_off:32'h4, exp_err:0, exp_rdata:0, exp_cyc:2};
    vecs[2]  = '{we:0, addr:32'h2000_0000, wdata:0, be:4'hF, ack_k:0, ack_rdata:0, stray:1,
                 exp_sel:4'b0000, exp_off:0, exp_err:1, exp_rdata:0, exp_cyc:1};
    vecs[3]  = '{we:0, addr:32'h0040_0FFF, wdata:0, be:4'hF, ack_k:2, ack_rdata:32'h0123_4567, stray:-1,
                 exp_sel:4'b0001, exp_off:32'hFFF, exp_err:0, exp_rdata:32'h0123_4567, exp_cyc:3};
    vecs[4]  = '{we:0, addr:32'h0040_1000, wdata:0, be:4'hF, ack_k:1, ack_rdata:32'h1, stray:-1,
                 exp_sel:4'b0000, exp_off:0, exp_err:1, exp_rdata:0, exp_cyc:1};
    vecs[5]  = '{we:1, addr:32'h7FFF_EFFC, wdata:32'hCAFE_F00D, be:4'hF, ack_k:0, ack_rdata:0, stray:0,
                 exp_sel:4'b0100, exp_off:32'h7FC, exp_err:1, exp_rdata:0, exp_cyc:T+1};
    vecs[6]  = '{we:0, addr:32'h7FFF_E800, wdata:0, be:4'hF, ack_k:T, ack_rdata:32'h5A5A_5A5A, stray:-1,
                 exp_sel:4'b0100, exp_off:32'h0, exp_err:0, exp_rdata:32'h5A5A_5A5A, exp_cyc:T+1};
    vecs[7]  = '{we:0, addr:32'h7FFF_E804, wdata:0, be:4'hF, ack_k:T+1, ack_rdata:32'h7777_7777, stray:-1,
                 exp_sel:4'b0100, exp_off:32'h4, exp_err:1, exp_rdata:0, exp_cyc:T+1};
    vecs[8]  = '{we:0, addr:32'hFFFF_00FF, wdata:0, be:4'h1, ack_k:1, ack_rdata:32'h0000_0011, stray:-1,
                 exp_sel:4'b1000, exp_off:32'hFF, exp_err:0, exp_rdata:32'h11, exp_cyc:2};
    vecs[9]  = '{we:0, addr:32'hFFFF_0100, wdata:0, be:4'hF, ack_k:1, ack_rdata:0, stray:-1,
                 exp_sel:4'b0000, exp_off:0, exp_err:1, exp_rdata:0, exp_cyc:1};
    vecs[10] = '{we:0, addr:32'h003F_FFFF, wdata:0, be:4'hF, ack_k:0, ack_rdata:0, stray:-1,
                 exp_sel:4'b0000, exp_off:0, exp_err:1, exp_rdata:0, exp_cyc:1};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    reg_rdata = '0;
    reg_ack   = '0;
    repeat (2) @(negedge clk);

    chk("reset.req_ready",  {31'b0, req_ready}, 32'd1);
    chk("reset.rsp_valid",  {31'b0, rsp_valid}, 32'd0);
    chk("reset.rsp_err",    {31'b0, rsp_err},   32'd0);
    chk("reset.rsp_rdata",  rsp_rdata,          32'd0);
    chk("reset.reg_sel",    {28'b0, reg_sel},   32'd0);
    chk("reset.reg_we",     {31'b0, reg_we},    32'd0);
    chk("reset.reg_offset", reg_offset,         32'd0);
    chk("reset.reg_wdata",  reg_wdata,          32'd0);
    chk("reset.reg_be",     {28'b0, reg_be},    32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset two cycles into an access: select drops at once and no response follows.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h1001_0020;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_mid.sel_before", {28'b0, reg_sel}, 32'b0010);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid.sel_async", {28'b0, reg_sel},   32'd0);
    chk("rst_mid.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_mid.ready",     {31'b0, req_ready}, 32'd1);
    repeat (2) begin
      @(negedge clk);
      chk("rst_mid.no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    v = '{we:0, addr:32'h1001_0020, wdata:0, be:4'hF, ack_k:2, ack_rdata:32'hFACE_0001, stray:-1,
          exp_sel:4'b0010, exp_off:32'h20, exp_err:0, exp_rdata:32'hFACE_0001, exp_cyc:3};
    run_txn(v, "rst_mid.after");

    // Random traffic against the address-map model.
    for (int n = 0; n < 60; n++) begin
      r    = $urandom_range(0, 3);
      mode = $urandom_range(0, 3);
      case (mode)
        0, 1:    v.addr = rb[r] + $urandom_range(0, rs[r] - 1);
        2:       v.addr = $urandom_range(0, 1) ? (rb[r] + rs[r]) : (rb[r] - 32'd1);
        default: v.addr = $urandom;
      endcase
      reg_i       = model_region(v.addr);
      v.we        = 1'($urandom);
      v.wdata     = $urandom;
      v.be        = 4'($urandom);
      v.ack_k     = $urandom_range(0, T + 2);
      v.ack_rdata = $urandom;
      v.stray     = -1;
      if ($urandom_range(0, 1) == 1) begin
        v.stray = $urandom_range(0, 3);
        if (v.stray == reg_i) v.stray = (v.stray + 1) % 4;
      end
      acked       = (reg_i >= 0) && (v.ack_k >= 1) && (v.ack_k <= T);
      v.exp_sel   = (reg_i >= 0) ? 4'(1 << reg_i) : 4'b0;
      v.exp_off   = (reg_i >= 0) ? (v.addr - rb[reg_i]) : 32'd0;
      v.exp_err   = !acked;
      v.exp_cyc   = (reg_i < 0) ? 1 : (acked ? v.ack_k + 1 : T + 1);
      v.exp_rdata = (acked && !v.we) ? v.ack_rdata : 32'd0;
      run_txn(v, $sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
